// File: rtl/serial_subtractor_8b.sv
// Bit-serial subtractor: diff = in_a - in_b - bin, one bit per clock, LSB first.
// Optional signed-overflow output is built when SUB_SIGNED_OVF_EN is defined.
module serial_subtractor_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             bin,
  output logic             start_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             accept, last_bit;
  logic             a_i, b_i, d, br_nx;

  assign start_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept      = start && start_ready;
  assign out_valid   = (state == DONE);
  assign last_bit    = (cnt == CNT_W'(WIDTH - 1));

  // One full-subtractor cell, fed from the LSB of the right-shifting operands.
  assign a_i   = a_sh[0];
  assign b_i   = b_sh[0];
  assign d     = a_i ^ b_i ^ br;
  assign br_nx = (~a_i & b_i) | (br & ~(a_i ^ b_i));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE: begin
        if (accept)         state_nx = SHIFT;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // diff doubles as the result shift register; it only moves during SHIFT,
  // so it holds through DONE and afterwards in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      a_sh <= in_a;
      b_sh <= in_b;
      br   <= bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_nx;
      diff <= {d, diff[WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
      if (last_bit) bout <= br_nx;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  // Operand MSBs are shifted out early, so keep copies for the overflow term.
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= in_a[WIDTH-1];
      b_msb <= in_b[WIDTH-1];
    end else if ((state == SHIFT) && last_bit) begin
      ovf <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor_8b.sv
// Scoreboard bench for serial_subtractor_8b: the driver queues expected results,
// an independent monitor pops and compares on every accepted output.
module tb_serial_subtractor_8b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_a, in_b;
  logic       bin;
  logic       start_ready, out_valid, out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef SUB_SIGNED_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic rand_rdy = 1'b0;
  logic ready_fixed = 1'b1;

  serial_subtractor_8b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_a        (in_a),
    .in_b        (in_b),
    .bin         (bin),
    .start_ready (start_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .bout        (bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sole driver of out_ready; settles at posedge+3, before the negedge sample.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: a result is consumed on the edge following a negedge where
  // out_valid && out_ready, so each result is compared exactly once.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(diff), 32'(e.diff));
        check("bout", 32'(bout), 32'(e.bout));
`ifdef SUB_SIGNED_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Hold start until accepted; returns at accept edge + 1.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic eo);
    logic ok;
    int   n;
    exp_t e;
    ok = 1'b0;
    n  = 0;
    start = 1'b1; in_a = a; in_b = b; bin = bi;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = start_ready;
      @(posedge clk);
      n++;
    end
    #1;
    start = 1'b0;
    in_a = ~a; in_b = ~b; bin = ~bi;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: start never accepted for a=0x%0h b=0x%0h", a, b);
    end else begin
      e.diff = ed; e.bout = eb; e.ovf = eo;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       bi;
    logic [7:0] d;
    logic       bo, ov;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   lat;

    rst_n = 1'b0; start = 1'b0; in_a = '0; in_b = '0; bin = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("start_ready_after_reset", 32'(start_ready), 32'd1);

    // Basic subtract with exact latency.
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_valid(lat);
    check("latency_basic", 32'(lat), 32'd8);

    // Hand-computed directed vectors, back-to-back with ready held high.
    vecs.push_back('{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1});
    vecs.push_back('{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0});
    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].ov);
    repeat (12) @(posedge clk);
    #1;

    // Backpressure: result held for 5 cycles, start ignored meanwhile.
    ready_fixed = 1'b0;
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    wait_valid(lat);
    check("latency_stall", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; in_a = 8'h33; in_b = 8'h11; bin = 1'b1;
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_diff", 32'(diff), 32'h7F);
      check("stall_bout", 32'(bout), 32'd0);
      check("stall_start_ready", 32'(start_ready), 32'd0);
      @(posedge clk); #1;
    end
    ready_fixed = 1'b1;
    issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    wait_valid(lat);
    check("latency_back_to_back", 32'(lat), 32'd8);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of SHIFT (counter at bit 4): no result may appear.
    issue(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Fresh operation plus a start pulse during SHIFT that must be dropped.
    issue(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; in_a = 8'hFF; in_b = 8'h00; bin = 1'b0;
    @(negedge clk);
    check("shift_start_ready", 32'(start_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;

    // Short random run against the 9-bit reference model, with stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, b;
      logic       bi;
      logic [8:0] r;
      a  = 8'($urandom);
      b  = 8'($urandom);
      bi = 1'($urandom_range(0, 1));
      r  = {1'b0, a} - {1'b0, b} - {8'd0, bi};
      issue(a, b, bi, r[7:0], r[8], (a[7] != b[7]) && (r[7] != a[7]));
    end
    rand_rdy = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
